// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the two-master DRAM arbiter.
package dram_arb_pkg;

    typedef enum logic {
        PRI   = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_CNT_W        = 3;

    localparam int M0 = 0;
    localparam int M1 = 1;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied master-1 cycles; flags the last
// tolerated denial so the arbiter can force a grant next cycle.
module arb_starve_counter
    import dram_arb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign limit_hit = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dram_arbiter.sv
// Fixed-priority arbiter sharing the async-read data DRAM between the CPU (m0)
// and a secondary master (m1); m1 gets a one-cycle forced grant when starved.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              m1_forced
);

    arb_state_e state_q, state_d;
    logic [1:0] gnt;
    logic       m1_denied;
    logic       limit_hit;

    // Grants are held low during reset so nothing reaches the DRAM write port.
    always_comb begin
        gnt = '0;
        if (!cpu_rst) begin
            if (state_q == FORCE) begin
                gnt[M1] = m1_req;
                gnt[M0] = m0_req & ~m1_req;
            end else begin
                gnt[M0] = m0_req;
                gnt[M1] = m1_req & ~m0_req;
            end
        end
    end

    assign m0_gnt    = gnt[M0];
    assign m1_gnt    = gnt[M1];
    assign m1_forced = ~cpu_rst & (state_q == FORCE) & m1_req;
    assign m1_denied = ~cpu_rst & (state_q == PRI) & m1_req & ~gnt[M1];

    always_comb begin
        dram_addr  = '0;
        dram_wdata = '0;
        dram_we    = 1'b0;
        if (gnt[M0]) begin
            dram_addr  = m0_addr;
            dram_wdata = m0_wdata;
            dram_we    = m0_we;
        end else if (gnt[M1]) begin
            dram_addr  = m1_addr;
            dram_wdata = m1_wdata;
            dram_we    = m1_we;
        end
    end

    assign m0_rdata = gnt[M0] ? dram_rdata : '0;
    assign m1_rdata = gnt[M1] ? dram_rdata : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            PRI:     if (m1_denied && limit_hit) state_d = FORCE;
            FORCE:   state_d = PRI;
            default: state_d = PRI;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst)
            state_q <= PRI;
        else
            state_q <= state_d;
    end

    // Any cycle that is not a denied PRI request restarts the starvation count.
    arb_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .inc       (m1_denied),
        .clr       (~m1_denied),
        .limit_hit (limit_hit)
    );

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port, async-read data DRAM of the SoC between two masters.
  - Master 0 is the CPU data port.
  - Master 1 is a secondary requester, e.g. a debug/program loader or DMA engine.
- Master 0 has fixed priority. Master 1 is protected by a starvation counter that forces a one-cycle grant.
- Sits between the CPU core's dram_* bus and the DRAM instance; all DRAM traffic goes through it.

Parameters:
- ADDR_W, 32, address width of both masters and the DRAM port.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied m1 cycles before a forced m1 grant; legal range 1..2**CNT_W-1.
- CNT_W, 3, width of the wait counter.

Ports:
- cpu_clk  in  1  single clock, rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU requests a DRAM access this cycle.
- m0_we  in  1  CPU access is a write.
- m0_addr  in  ADDR_W  CPU address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_gnt  out  1  CPU access performed this cycle; if low, CPU must hold its request.
- m0_rdata  out  DATA_W  read data to CPU.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata: same as m0_* for master 1.
- dram_addr  out  ADDR_W  to DRAM.
- dram_we  out  1  to DRAM; the write commits at the cpu_clk edge.
- dram_wdata  out  DATA_W  to DRAM.
- dram_rdata  in  DATA_W  async read data from DRAM.
- m1_forced  out  1  high during a forced m1 grant cycle (debug).

Behaviour:
- Clock and reset: one clock, cpu_clk. Reset cpu_rst is synchronous and active-high.
- State machine: registered state ∈ {PRI, FORCE}; wait_cnt is CNT_W bits.
- Reset:
  - State becomes PRI and wait_cnt becomes 0.
  - While cpu_rst is high, m0_gnt=m1_gnt=dram_we=m1_forced=0 and both rdata outputs are 0, so no write can occur.
- Grant logic (combinational, zero latency; the access completes in the same cycle the grant is high):
  - PRI: m0_gnt=m0_req; m1_gnt=m1_req & ~m0_req.
  - FORCE: m1_gnt=m1_req; m0_gnt=m0_req & ~m1_req; m1_forced=m1_req.
- Datapath mux:
  - The granted master drives dram_addr and dram_wdata; dram_we = granted master's we.
  - With no grant, dram_addr=0, dram_wdata=0, dram_we=0.
  - m0_rdata = m0_gnt ? dram_rdata : 0; m1_rdata likewise.
- wait_cnt update:
  - In PRI, if m1_req & ~m1_gnt: wait_cnt increments, saturating at 2**CNT_W-1.
  - If m1_gnt, or if ~m1_req: wait_cnt is cleared to 0.
- Transitions:
  - PRI→FORCE when m1 is denied and wait_cnt == STARVE_LIMIT-1, i.e. after STARVE_LIMIT consecutive denied cycles.
  - FORCE→PRI unconditionally after one cycle; wait_cnt is cleared.
- FORCE with m1_req dropped: m0 is served that cycle, so no slot is wasted; return to PRI.
- Simultaneous requests in PRI: m0 wins.
- Master 1 with no competition: every cycle is granted and wait_cnt stays 0.
- Write-then-read: a same-address write by one master and a read by the other in the next cycle returns the new data, because the DRAM write commits at the edge.
- Reset asserted mid-FORCE: the next state is PRI and the pending forced grant is dropped.

Decomposition:
- Package dram_arb_pkg holds:
  - the state enum (PRI, FORCE);
  - the default STARVE_LIMIT and CNT_W constants;
  - the master index constants M0=0, M1=1.
- One natural sub-module, arb_starve_counter: saturating wait counter with a clear input and a limit-hit output.
- The grant/mux logic stays in the top.

Test Plan:
- Reset: hold cpu_rst high with both req=1 and we=1 → m0_gnt=m1_gnt=dram_we=0. After release, state is PRI and wait_cnt is 0.
- m0 alone: m0 writes 0xDEADBEEF to 0x10, then reads 0x10 → m0_gnt=1 both cycles and m0_rdata=0xDEADBEEF.
- m1 alone: m1 streams 8 writes → m1_gnt=1 every cycle, m1_forced stays 0, and the memory contents match.
- Starvation: m0_req and m1_req held high continuously with STARVE_LIMIT=4 → m1 is denied for cycles 1-4. In cycle 5, m1_gnt=1, m0_gnt=0 and m1_forced=1. The pattern then repeats every 5 cycles.
- FORCE with m1 drop: reach FORCE, then drop m1_req in that cycle → m0_gnt=1, m1_forced=0, and the state is PRI on the next cycle.
- Reset mid-operation: assert cpu_rst during a FORCE cycle that carries an m1 write → no DRAM write occurs, and after release m0 is granted immediately.
